// File: rtl/bunny_pkg.sv
// Shared types and constants for the bunny game sequencer.
package bunny_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    localparam int LAPS_MAX     = 255;
    localparam int DIV_BASE_DEF = 16;

endpackage

// File: rtl/bunny_tick_div.sv
// Step prescaler: counts enabled cycles and pulses tick on the last
// cycle of each period.
module bunny_tick_div #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [CNT_W-1:0] period,
    output logic             tick
);

    logic [CNT_W-1:0] cnt;

    assign tick = en && (cnt == period - 1'b1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/bunny_step_sched.sv
// Game FSM for the bunny datapath: owns position, lives, laps, period
// latching and start/pause/hit priority; the prescaler lives in bunny_tick_div.
module bunny_step_sched
    import bunny_pkg::*;
#(
    parameter int DIV_BASE  = DIV_BASE_DEF,
    parameter int NUM_LIVES = 3,
    parameter int POS_W     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             pause,
    input  logic             hit,
    input  logic [1:0]       speed_sel,
    output logic [POS_W-1:0] pos,
    output logic             step,
    output logic [1:0]       state,
    output logic [1:0]       lives,
    output logic [7:0]       laps,
    output logic             game_over
);

    localparam int CNT_W = $clog2(DIV_BASE) + 1;

    state_t           st;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] sel_period;
    logic             tick;
    logic             div_en;
    logic             div_clr;

    assign sel_period = CNT_W'(DIV_BASE >> speed_sel);
    assign state      = st;

    // A hit or pause in RUN pre-empts the prescaler for that cycle.
    assign div_en  = (st == ST_RUN) && !hit && !pause;
    assign div_clr = ((st == ST_IDLE) && start)
                   || ((st == ST_RUN) && hit);

    bunny_tick_div #(
        .CNT_W (CNT_W)
    ) u_div (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (div_en),
        .clr    (div_clr),
        .period (period),
        .tick   (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st        <= ST_IDLE;
            pos       <= '0;
            step      <= 1'b0;
            lives     <= 2'd0;
            laps      <= 8'd0;
            period    <= CNT_W'(DIV_BASE);
            game_over <= 1'b0;
        end else begin
            step <= 1'b0;
            unique case (st)
                ST_IDLE: begin
                    if (start) begin
                        st     <= ST_RUN;
                        pos    <= '0;
                        laps   <= 8'd0;
                        lives  <= 2'(NUM_LIVES);
                        period <= sel_period;
                    end
                end
                ST_RUN: begin
                    if (hit) begin
                        if (lives > 2'd1) begin
                            lives <= lives - 2'd1;
                            pos   <= '0;
                        end else begin
                            lives     <= 2'd0;
                            st        <= ST_OVER;
                            game_over <= 1'b1;
                        end
                    end else if (pause) begin
                        st <= ST_PAUSE;
                    end else if (tick) begin
                        pos    <= pos + 1'b1;
                        step   <= 1'b1;
                        period <= sel_period;
                        if (&pos && laps != 8'(LAPS_MAX)) begin
                            laps <= laps + 8'd1;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (pause) begin
                        st <= ST_RUN;
                    end
                end
                ST_OVER: begin
                    if (start) begin
                        st        <= ST_IDLE;
                        game_over <= 1'b0;
                    end
                end
                default: st <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bunny_step_sched.sv
// Randomized bench for bunny_step_sched against a cycle-level game model.
module tb_bunny_step_sched;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       pause;
    logic       hit;
    logic [1:0] speed_sel;
    logic [3:0] pos;
    logic       step;
    logic [1:0] state;
    logic [1:0] lives;
    logic [7:0] laps;
    logic       game_over;

    int checks;
    int failures;

    // Reference model of the game, kept as plain integers.
    int m_state;
    int m_pos;
    int m_step;
    int m_lives;
    int m_laps;
    int m_cnt;
    int m_per;

    bunny_step_sched dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .pause     (pause),
        .hit       (hit),
        .speed_sel (speed_sel),
        .pos       (pos),
        .step      (step),
        .state     (state),
        .lives     (lives),
        .laps      (laps),
        .game_over (game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_pos   = 0;
        m_step  = 0;
        m_lives = 0;
        m_laps  = 0;
        m_cnt   = 0;
        m_per   = 16;
    endtask

    task automatic model_step();
        m_step = 0;
        case (m_state)
            0: if (start) begin
                m_state = 1;
                m_pos   = 0;
                m_laps  = 0;
                m_lives = 3;
                m_cnt   = 0;
                m_per   = 16 >> speed_sel;
            end
            1: if (hit) begin
                if (m_lives > 1) begin
                    m_lives--;
                    m_pos = 0;
                    m_cnt = 0;
                end else begin
                    m_lives = 0;
                    m_state = 3;
                end
            end else if (pause) begin
                m_state = 2;
            end else if (m_cnt == m_per - 1) begin
                m_cnt  = 0;
                m_pos  = (m_pos + 1) % 16;
                m_step = 1;
                m_per  = 16 >> speed_sel;
                if (m_pos == 0 && m_laps < 255) m_laps++;
            end else begin
                m_cnt++;
            end
            2: if (pause) m_state = 1;
            default: if (start) m_state = 0;
        endcase
    endtask

    task automatic compare_all();
        check("state", int'(state), m_state);
        check("pos", int'(pos), m_pos);
        check("step", int'(step), m_step);
        check("lives", int'(lives), m_lives);
        check("laps", int'(laps), m_laps);
        check("game_over", int'(game_over), int'(m_state == 3));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
        start = 1'b0;
        pause = 1'b0;
        hit   = 1'b0;
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        pause     = 1'b0;
        hit       = 1'b0;
        speed_sel = 2'd0;
        model_reset();
        #12;
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        pause = 1'b1;
        hit   = 1'b1;
        cycle();
        check("idle_ignore", int'(state), 0);

        // First step lands exactly one period after the start edge.
        start = 1'b1;
        cycle();
        check("run_after_start", int'(state), 1);
        repeat (15) cycle();
        check("pos_before_16", int'(pos), 0);
        cycle();
        check("pos_at_16", int'(pos), 1);
        check("step_at_16", int'(step), 1);
        cycle();
        check("step_one_cycle", int'(step), 0);

        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 49) == 0) speed_sel = 2'($urandom);
            start = ($urandom_range(0, 59) == 0);
            pause = ($urandom_range(0, 39) == 0);
            hit   = ($urandom_range(0, 149) == 0);
            cycle();
            if (i % 1500 == 1499) do_reset();
        end

        // Pause/hit while idle after a reset change nothing.
        do_reset();
        pause = 1'b1;
        cycle();
        hit = 1'b1;
        cycle();
        check("idle_after_rst", int'(state), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
